// File: rtl/can_rx_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the CAN receive path: buffer geometry and the buffer
// controller state encoding.
package can_rx_pkg;

  localparam int BUF_DEPTH = 13;
  localparam int MAX_DLC   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_CMIT = 2'd2,
    ST_FULL = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rx_buf_ctrl.sv
`timescale 1ns/1ps
// Receive buffer controller: stores frame bytes, validates length against DLC, holds one frame.
// Writes land one cycle after byte_vld; rbs/rx_int two cycles after frm_ok; no backpressure, a held buffer raises dor.
module rx_buf_ctrl #(
  parameter int BUF_DEPTH = can_rx_pkg::BUF_DEPTH,
  parameter int MAX_DLC   = can_rx_pkg::MAX_DLC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frm_start,
  input  logic       byte_vld,
  input  logic [7:0] byte_din,
  input  logic       frm_ok,
  input  logic       frm_err,
  input  logic       rel_buf,
  input  logic       clr_dor,
  output logic [3:0] b_addr,
  output logic [7:0] b_din,
  output logic       b_wrn,
  output logic       rbs,
  output logic       dor,
  output logic       rx_int,
  output logic       len_err
);

  import can_rx_pkg::rx_state_t;
  import can_rx_pkg::ST_IDLE;
  import can_rx_pkg::ST_RECV;
  import can_rx_pkg::ST_CMIT;
  import can_rx_pkg::ST_FULL;

  localparam logic [3:0] DEPTH_Q = 4'(BUF_DEPTH);
  localparam logic [3:0] DLC_CAP = 4'(MAX_DLC);

  rx_state_t  state_q, state_d;
  logic [3:0] wptr_q, wptr_d;
  logic [4:0] hdr_q;
  logic [4:0] hdr_cur;
  logic [3:0] dlc_eff;
  logic [3:0] exp_cnt;
  logic [3:0] cnt_fin;
  logic       wr_en;
  logic       hdr_en;
  logic       len_err_d;
  logic       dor_set;

  // A restart or abort in the same cycle wins over the byte strobe.
  assign wr_en  = (state_q == ST_RECV) && byte_vld && !frm_start && !frm_err &&
                  (wptr_q < DEPTH_Q);
  assign hdr_en = wr_en && (wptr_q == 4'd1);

  // The header byte may arrive in the same cycle as frm_ok, so bypass the register.
  always_comb begin
    hdr_cur = hdr_en ? byte_din[4:0] : hdr_q;
    dlc_eff = (hdr_cur[3:0] > DLC_CAP) ? DLC_CAP : hdr_cur[3:0];
    exp_cnt = hdr_cur[4] ? 4'd2 : (4'd2 + dlc_eff);
    cnt_fin = wptr_q + {3'd0, wr_en};
  end

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    len_err_d = 1'b0;
    if (wr_en) begin
      wptr_d = wptr_q + 4'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (frm_start) begin
          wptr_d  = 4'd0;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (frm_start) begin
          wptr_d = 4'd0;
        end else if (frm_err) begin
          state_d = ST_IDLE;
        end else if (frm_ok) begin
          if (cnt_fin == exp_cnt) begin
            state_d = ST_CMIT;
          end else begin
            len_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_CMIT: begin
        state_d = ST_FULL;
      end
      ST_FULL: begin
        if (rel_buf) begin
          if (frm_start) begin
            wptr_d  = 4'd0;
            state_d = ST_RECV;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dor_set = (state_q == ST_FULL) && frm_ok && !rel_buf;
  assign rbs     = (state_q == ST_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wptr_q  <= 4'd0;
      hdr_q   <= 5'd0;
      b_wrn   <= 1'b1;
      b_addr  <= 4'd0;
      b_din   <= 8'd0;
      dor     <= 1'b0;
      rx_int  <= 1'b0;
      len_err <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      if (hdr_en) begin
        hdr_q <= byte_din[4:0];
      end
      b_wrn <= ~wr_en;
      if (wr_en) begin
        b_addr <= wptr_q;
        b_din  <= byte_din;
      end
      // Set dominates a simultaneous clear.
      dor     <= dor_set | (dor & ~clr_dor);
      rx_int  <= (state_q == ST_CMIT);
      len_err <= len_err_d;
    end
  end

endmodule

// File: tb/tb_rx_buf_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for rx_buf_ctrl: stimulus queues expected writes/pulses, a negedge monitor pops them.
module tb_rx_buf_ctrl;

  localparam int K_WR  = 1;
  localparam int K_INT = 2;
  localparam int K_LEN = 3;

  typedef struct {
    int         kind;
    logic [3:0] addr;
    logic [7:0] data;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       frm_start;
  logic       byte_vld;
  logic [7:0] byte_din;
  logic       frm_ok;
  logic       frm_err;
  logic       rel_buf;
  logic       clr_dor;
  logic [3:0] b_addr;
  logic [7:0] b_din;
  logic       b_wrn;
  logic       rbs;
  logic       dor;
  logic       rx_int;
  logic       len_err;

  evt_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  rx_buf_ctrl #(.BUF_DEPTH(13), .MAX_DLC(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .frm_start(frm_start),
    .byte_vld (byte_vld),
    .byte_din (byte_din),
    .frm_ok   (frm_ok),
    .frm_err  (frm_err),
    .rel_buf  (rel_buf),
    .clr_dor  (clr_dor),
    .b_addr   (b_addr),
    .b_din    (b_din),
    .b_wrn    (b_wrn),
    .rbs      (rbs),
    .dor      (dor),
    .rx_int   (rx_int),
    .len_err  (len_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic push(input int kind, input logic [3:0] a, input logic [7:0] d);
    evt_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic take(input int kind, input logic [3:0] a, input logic [7:0] d);
    evt_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_evt: got kind %0d addr %0d data 0x%0h, want no event", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      check("evt_kind", 32'(kind), 32'(e.kind));
      if (kind == K_WR && e.kind == K_WR) begin
        check("wr_addr", 32'(a), 32'(e.addr));
        check("wr_data", 32'(d), 32'(e.data));
      end
    end
  endtask

  // Monitor: every observed output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (b_wrn === 1'b0) take(K_WR, b_addr, b_din);
    if (rx_int === 1'b1) take(K_INT, 4'd0, 8'd0);
    if (len_err === 1'b1) take(K_LEN, 4'd0, 8'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
    frm_start = 1'b0;
    byte_vld  = 1'b0;
    frm_ok    = 1'b0;
    frm_err   = 1'b0;
    rel_buf   = 1'b0;
    clr_dor   = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic wr, input logic [3:0] a);
    byte_vld = 1'b1;
    byte_din = b;
    if (wr) push(K_WR, a, b);
    step();
  endtask

  task automatic start();
    frm_start = 1'b1;
    step();
  endtask

  initial begin
    logic [7:0] frm1 [5];
    frm1[0] = 8'h12; frm1[1] = 8'h63; frm1[2] = 8'hA1; frm1[3] = 8'hA2; frm1[4] = 8'hA3;
    rst = 1'b1; frm_start = 0; byte_vld = 0; byte_din = 0;
    frm_ok = 0; frm_err = 0; rel_buf = 0; clr_dor = 0;
    step();
    step();
    check("rst_b_wrn", 32'(b_wrn), 1);
    check("rst_b_addr", 32'(b_addr), 0);
    check("rst_b_din", 32'(b_din), 0);
    check("rst_rbs", 32'(rbs), 0);
    check("rst_dor", 32'(dor), 0);
    rst = 1'b0;
    step();

    // Data frame, DLC=3.
    start();
    for (int i = 0; i < 5; i++) send(frm1[i], 1'b1, 4'(i));
    push(K_INT, 0, 0);
    frm_ok = 1'b1;
    step();
    check("dlc3_rbs_cmit", 32'(rbs), 0);
    step();
    check("dlc3_rbs_full", 32'(rbs), 1);

    // Second frame while FULL: no writes, overrun.
    start();
    send(8'h11, 1'b0, 0);
    send(8'h18, 1'b0, 0);
    frm_ok = 1'b1;
    step();
    check("full_dor_set", 32'(dor), 1);
    check("full_rbs_held", 32'(rbs), 1);
    clr_dor = 1'b1;
    step();
    check("clr_dor", 32'(dor), 0);
    rel_buf = 1'b1;
    step();
    check("rel_rbs", 32'(rbs), 0);

    // RTR frame, last byte in the frm_ok cycle.
    start();
    send(8'h55, 1'b1, 0);
    push(K_WR, 1, 8'h18);
    push(K_INT, 0, 0);
    byte_vld = 1'b1; byte_din = 8'h18; frm_ok = 1'b1;
    step();
    step();
    check("rtr_rbs", 32'(rbs), 1);

    // Release and restart together; RTR frame with an extra byte.
    rel_buf = 1'b1; frm_start = 1'b1;
    step();
    check("rel_start_rbs", 32'(rbs), 0);
    send(8'h55, 1'b1, 0);
    send(8'h18, 1'b1, 1);
    send(8'h77, 1'b1, 2);
    push(K_LEN, 0, 0);
    frm_ok = 1'b1;
    step();
    step();
    check("rtr_len_rbs", 32'(rbs), 0);

    // Overflow: 15 bytes, DLC=15, only addr 0..12 written.
    start();
    send(8'hAB, 1'b1, 0);
    send(8'h0F, 1'b1, 1);
    for (int i = 2; i < 15; i++) send(8'(8'h20 + i), (i < 13), 4'(i));
    push(K_LEN, 0, 0);
    frm_ok = 1'b1;
    step();
    step();
    check("ovf_rbs", 32'(rbs), 0);

    // Restart mid-frame rewinds to addr 0.
    start();
    send(8'hAA, 1'b1, 0);
    start();
    for (int i = 0; i < 5; i++) send(frm1[i], 1'b1, 4'(i));
    push(K_INT, 0, 0);
    frm_ok = 1'b1;
    step();
    step();
    check("restart_rbs", 32'(rbs), 1);
    frm_ok = 1'b1; clr_dor = 1'b1;
    step();
    check("dor_set_wins", 32'(dor), 1);
    rel_buf = 1'b1; frm_ok = 1'b1;
    step();
    check("rel_ok_rbs", 32'(rbs), 0);
    check("rel_ok_dor", 32'(dor), 1);

    // Abort: no flags change, later frm_ok ignored in IDLE.
    start();
    send(8'h01, 1'b1, 0);
    frm_err = 1'b1;
    step();
    frm_ok = 1'b1;
    step();
    step();
    check("err_rbs", 32'(rbs), 0);
    check("err_dor", 32'(dor), 1);

    // Reset in the cycle after a byte strobe.
    start();
    send(8'h99, 1'b1, 0);
    rst = 1'b1;
    step();
    check("mid_rst_b_wrn", 32'(b_wrn), 1);
    check("mid_rst_b_addr", 32'(b_addr), 0);
    check("mid_rst_b_din", 32'(b_din), 0);
    check("mid_rst_rbs", 32'(rbs), 0);
    check("mid_rst_dor", 32'(dor), 0);
    check("mid_rst_rx_int", 32'(rx_int), 0);
    check("mid_rst_len_err", 32'(len_err), 0);
    rst = 1'b0;
    step();
    // Back in IDLE: bytes and frm_ok without frm_start must be ignored.
    send(8'h44, 1'b0, 0);
    frm_ok = 1'b1;
    step();
    step();
    step();
    check("idle_rbs", 32'(rbs), 0);
    check("evt_q_left", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_buf_ctrl.md
RX_BUF_CTRL -- requirements
Module: rx_buf_ctrl

Interface
REQ-001 The block SHALL have the parameter BUF_DEPTH, default 13, giving the number of buffer bytes.
REQ-002 The block SHALL have the parameter MAX_DLC, default 8, giving the maximum data bytes counted from DLC.
REQ-003 The block SHALL have the port clk, input, 1 bit: single clock; all logic is synchronous to its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have the port frm_start, input, 1 bit: single-cycle pulse at start of a received frame.
REQ-006 The block SHALL have the port byte_vld, input, 1 bit: single-cycle strobe qualifying byte_din.
REQ-007 The block SHALL have the port byte_din, input, 8 bits: received frame byte (byte0 = ID[10:3]; byte1 = ID[2:0], RTR, DLC[3:0]).
REQ-008 The block SHALL have the port frm_ok, input, 1 bit: single-cycle pulse, frame ended with valid CRC/EOF.
REQ-009 The block SHALL have the port frm_err, input, 1 bit: single-cycle pulse, frame aborted.
REQ-010 The block SHALL have the port rel_buf, input, 1 bit: single-cycle CPU release-buffer command.
REQ-011 The block SHALL have the port clr_dor, input, 1 bit: single-cycle CPU clear-data-overrun command.
REQ-012 The block SHALL have the port b_addr, output, 4 bits: buffer write address.
REQ-013 The block SHALL have the port b_din, output, 8 bits: buffer write data.
REQ-014 The block SHALL have the port b_wrn, output, 1 bit: buffer write strobe, active low.
REQ-015 The block SHALL have the port rbs, output, 1 bit: receive buffer status; a complete frame is held.
REQ-016 The block SHALL have the port dor, output, 1 bit: sticky data-overrun flag.
REQ-017 The block SHALL have the port rx_int, output, 1 bit: single-cycle frame-received pulse.
REQ-018 The block SHALL have the port len_err, output, 1 bit: single-cycle pulse, byte count mismatched DLC.

Function
REQ-019 The block SHALL use the states IDLE (buffer free), RECV (storing), CMIT (draining last write) and FULL (frame held, rbs=1).
REQ-020 IDLE: frm_start SHALL load wptr=0 and move to RECV; byte_vld/frm_ok/frm_err SHALL be ignored.
REQ-021 RECV: byte_vld with wptr<BUF_DEPTH SHALL register b_addr=wptr and b_din=byte_din, drive b_wrn=0 for exactly the next cycle, and increment wptr.
REQ-022 RECV: byte_vld with wptr=BUF_DEPTH SHALL produce no write and leave wptr saturated, with no wrap-around.
REQ-023 The block SHALL capture byte1 as the header, giving expected count = 2 if RTR=1, else 2+min(DLC,MAX_DLC); all count arithmetic is 4-bit unsigned.
REQ-024 RECV frm_ok: if the final count (including a same-cycle byte_vld) equals the expected count, the block SHALL go to CMIT; otherwise it SHALL pulse len_err and return to IDLE.
REQ-025 CMIT SHALL last one cycle, then go to FULL; the cycle FULL is entered, rbs SHALL rise and rx_int SHALL pulse, so the last byte is in the buffer before rbs=1.
REQ-026 RECV frm_err SHALL return to IDLE with no flag change; a pending write still completes.
REQ-027 RECV frm_start (restart) SHALL reset wptr=0 and stay in RECV.
REQ-028 FULL: rel_buf SHALL clear rbs and go to IDLE; if frm_start arrives in the same cycle, the block SHALL go directly to RECV with wptr=0.
REQ-029 FULL: frm_ok without a same-cycle rel_buf SHALL set dor; frame bytes SHALL never be written while in FULL.
REQ-030 rel_buf SHALL be ignored in IDLE, RECV and CMIT.
REQ-031 clr_dor SHALL clear dor; simultaneous set and clear SHALL leave dor=1.
REQ-032 Outside write cycles, b_wrn SHALL be 1; b_addr and b_din SHALL hold their last values.

Reset
REQ-033 While rst=1 at a clock edge: state=IDLE, wptr=0, b_wrn=1, b_addr=0, b_din=0, rbs=0, dor=0, rx_int=0, len_err=0.
REQ-034 Reset mid-frame SHALL abandon the frame, and no write strobe SHALL follow; buffer contents are not cleared by this block.

Structure
REQ-035 State encodings, BUF_DEPTH and MAX_DLC SHALL be defined in the shared package can_rx_pkg.
REQ-036 The block SHALL be a single module with no sub-modules; DLC decode is inline combinational logic.

Verification
REQ-037 Data frame DLC=3: bytes 0x12,0x63,0xA1,0xA2,0xA3 then frm_ok -> five writes to addr 0..4 with those values; rbs=1 and one rx_int pulse two cycles after frm_ok.
REQ-038 RTR frame: bytes 0x55,0x18 then frm_ok -> two writes, rbs=1; the same frame with a third byte -> len_err pulse, rbs=0.
REQ-039 While FULL, a second frame with frm_ok -> no b_wrn=0 cycles, dor=1; then clr_dor -> dor=0; then rel_buf -> rbs=0.
REQ-040 rel_buf and frm_start in the same cycle while FULL -> rbs=0 the next cycle, and the new frame is stored from addr 0.
REQ-041 15 byte_vld strobes, DLC=15 -> writes to addr 0..12 only, with no wrap to addr 0; frm_ok -> len_err (expected 10, got 13).
REQ-042 rst asserted in the cycle after byte_vld while in RECV -> b_wrn=1 the following cycle, all outputs at reset values, state IDLE.
